hist_cdf_engine: RTL and testbench

//  Streaming per-frame histogram plus CDF generator for the histogram-equalisation path.

---
 rtl/hist_cdf_engine_pkg.sv | 33 +++
 rtl/hist_cdf_engine_if.sv | 43 ++++
 rtl/hist_cdf_engine_ram.sv | 25 ++
 rtl/hist_cdf_engine.sv | 159 +++++++++++++++
 tb/tb_hist_cdf_engine.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/hist_cdf_engine_pkg.sv
// Shared types and helpers for the histogram/CDF engine: FSM states, size
// derivation and saturating arithmetic used on bin counts and running sums.
package hist_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR,
        ST_ACCUM,
        ST_DRAIN,
        ST_SCAN
    } state_t;

    function automatic int levels_f(input int pix_w);
        return 1 << pix_w;
    endfunction

    function automatic int cnt_w_f(input int image_size);
        return $clog2(image_size + 1);
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic [31:0] max_v);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max_v}) ? max_v : s[31:0];
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] a,
                                            input logic [31:0] max_v);
        return sat_add(a, 32'd1, max_v);
    endfunction

endpackage

// File: rtl/hist_cdf_engine_if.sv
// Pixel input and CDF output stream of the histogram engine.
// o_cdf_min exists only when HIST_CDF_MIN_EN is defined.
interface hist_cdf_if #(
    parameter int PIX_W = 8,
    parameter int CNT_W = 19
);
    logic [PIX_W-1:0] i_pixel;
    logic             i_pixel_valid;
    logic             i_frame_end;
    logic             i_cdf_ready;
    logic             o_busy;
    logic             o_drop_err;
    logic             o_cdf_valid;
    logic [PIX_W-1:0] o_cdf_bin;
    logic [CNT_W-1:0] o_cdf_data;
    logic             o_cdf_last;
    logic             o_frame_done;
`ifdef HIST_CDF_MIN_EN
    logic [CNT_W-1:0] o_cdf_min;

    modport slave (
        input  i_pixel, i_pixel_valid, i_frame_end, i_cdf_ready,
        output o_busy, o_drop_err, o_cdf_valid, o_cdf_bin, o_cdf_data,
               o_cdf_last, o_frame_done, o_cdf_min
    );
    modport master (
        output i_pixel, i_pixel_valid, i_frame_end, i_cdf_ready,
        input  o_busy, o_drop_err, o_cdf_valid, o_cdf_bin, o_cdf_data,
               o_cdf_last, o_frame_done, o_cdf_min
    );
`else
    modport slave (
        input  i_pixel, i_pixel_valid, i_frame_end, i_cdf_ready,
        output o_busy, o_drop_err, o_cdf_valid, o_cdf_bin, o_cdf_data,
               o_cdf_last, o_frame_done
    );
    modport master (
        output i_pixel, i_pixel_valid, i_frame_end, i_cdf_ready,
        input  o_busy, o_drop_err, o_cdf_valid, o_cdf_bin, o_cdf_data,
               o_cdf_last, o_frame_done
    );
`endif
endinterface

// File: rtl/hist_cdf_engine_ram.sv
// Bin storage: simple dual-port RAM, one write and one read port,
// 1-cycle synchronous read returning the pre-write contents on a collision.
module hist_ram
    import hist_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 19
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] mem_q [levels_f(ADDR_W)];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) mem_q[i_waddr] <= i_wdata;
        rdata_q <= mem_q[i_raddr];
    end

    assign o_rdata = rdata_q;
endmodule

// File: rtl/hist_cdf_engine.sv
// Per-frame histogram with streamed cumulative output for histogram equalisation.
// Optional HIST_CDF_MIN_EN adds o_cdf_min (first nonzero CDF value of the last frame).
//
// state | meaning
// CLEAR | zero every bin, one per cycle
// ACCUM | accept pixels, 2-stage read-modify-write per pixel
// DRAIN | 2 cycles for the RMW pipeline to retire
// SCAN  | stream running sum per bin, zero each bin as it is accepted
module hist_cdf_engine
    import hist_pkg::*;
#(
    parameter int PIX_W      = 8,
    parameter int IMAGE_SIZE = 640*480,
    parameter int CNT_W      = cnt_w_f(IMAGE_SIZE)
) (
    input logic       i_clk,
    input logic       i_reset_n,
    hist_cdf_if.slave hist_if
);
    localparam logic [31:0] CNT_MAX = 32'((33'd1 << CNT_W) - 33'd1);

    state_t           state_q;
    logic [PIX_W-1:0] idx_q;
    logic             drain_q;
    logic             s0_vld_q;
    logic [PIX_W-1:0] s0_bin_q;
    logic             wr_vld_q;
    logic [PIX_W-1:0] wr_bin_q;
    logic [CNT_W-1:0] wr_val_q;
    logic [CNT_W-1:0] sum_q;
    logic             valid_q;
    logic             done_q;
    logic             drop_q;

    logic             ram_we;
    logic [PIX_W-1:0] ram_waddr;
    logic [CNT_W-1:0] ram_wdata;
    logic [PIX_W-1:0] ram_raddr;
    logic [CNT_W-1:0] ram_rdata;
    logic [CNT_W-1:0] cur_cnt;
    logic [CNT_W-1:0] inc_cnt;
    logic [CNT_W-1:0] cdf_sum;
    logic             hs;

    hist_ram #(.ADDR_W(PIX_W), .DATA_W(CNT_W)) u_ram (
        .i_clk   (i_clk),
        .i_we    (ram_we),
        .i_waddr (ram_waddr),
        .i_wdata (ram_wdata),
        .i_raddr (ram_raddr),
        .o_rdata (ram_rdata)
    );

    always_comb begin
        // The read of a same-bin pixel one cycle behind misses the write; forward it.
        cur_cnt   = (wr_vld_q && wr_bin_q == s0_bin_q) ? wr_val_q : ram_rdata;
        inc_cnt   = CNT_W'(sat_inc(32'(cur_cnt), CNT_MAX));
        cdf_sum   = CNT_W'(sat_add(32'(sum_q), 32'(ram_rdata), CNT_MAX));
        hs        = valid_q && hist_if.i_cdf_ready;
        ram_raddr = idx_q;
        if (state_q == ST_ACCUM)
            ram_raddr = hist_if.i_pixel;
        else if (state_q == ST_SCAN && hs)
            ram_raddr = idx_q + PIX_W'(1);
        ram_we    = 1'b0;
        ram_waddr = idx_q;
        ram_wdata = '0;
        if (s0_vld_q) begin
            ram_we    = 1'b1;
            ram_waddr = s0_bin_q;
            ram_wdata = inc_cnt;
        end else if (state_q == ST_CLEAR || (state_q == ST_SCAN && hs)) begin
            ram_we    = 1'b1;
        end
    end

`ifdef HIST_CDF_MIN_EN
    logic [CNT_W-1:0] min_run_q;
    logic [CNT_W-1:0] cdf_min_q;
    assign hist_if.o_cdf_min = cdf_min_q;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= ST_CLEAR;
            idx_q    <= '0;
            drain_q  <= 1'b0;
            s0_vld_q <= 1'b0;
            s0_bin_q <= '0;
            wr_vld_q <= 1'b0;
            wr_bin_q <= '0;
            wr_val_q <= '0;
            sum_q    <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
`ifdef HIST_CDF_MIN_EN
            min_run_q <= '0;
            cdf_min_q <= '0;
`endif
        end else begin
            done_q   <= 1'b0;
            drop_q   <= (hist_if.i_pixel_valid || hist_if.i_frame_end) && state_q != ST_ACCUM;
            s0_vld_q <= 1'b0;
            s0_bin_q <= hist_if.i_pixel;
            wr_vld_q <= s0_vld_q;
            wr_bin_q <= s0_bin_q;
            wr_val_q <= inc_cnt;
            case (state_q)
                ST_CLEAR: begin
                    idx_q <= idx_q + PIX_W'(1);
                    if (idx_q == '1) state_q <= ST_ACCUM;
                end
                ST_ACCUM: begin
                    s0_vld_q <= hist_if.i_pixel_valid;
                    if (hist_if.i_frame_end) begin
                        state_q <= ST_DRAIN;
                        drain_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    drain_q <= 1'b1;
                    if (drain_q) state_q <= ST_SCAN;
                end
                ST_SCAN: begin
                    // First SCAN cycle only issues the read of bin 0.
                    if (!valid_q) begin
                        valid_q <= 1'b1;
                    end else if (hist_if.i_cdf_ready) begin
                        idx_q <= idx_q + PIX_W'(1);
                        sum_q <= cdf_sum;
`ifdef HIST_CDF_MIN_EN
                        if (min_run_q == '0) min_run_q <= cdf_sum;
`endif
                        if (idx_q == '1) begin
                            valid_q <= 1'b0;
                            done_q  <= 1'b1;
                            sum_q   <= '0;
                            state_q <= ST_ACCUM;
`ifdef HIST_CDF_MIN_EN
                            cdf_min_q <= (min_run_q != '0) ? min_run_q : cdf_sum;
                            min_run_q <= '0;
`endif
                        end
                    end
                end
                default: state_q <= ST_CLEAR;
            endcase
        end
    end

    assign hist_if.o_busy       = (state_q != ST_ACCUM);
    assign hist_if.o_drop_err   = drop_q;
    assign hist_if.o_cdf_valid  = valid_q;
    assign hist_if.o_cdf_bin    = valid_q ? idx_q : '0;
    assign hist_if.o_cdf_data   = valid_q ? cdf_sum : '0;
    assign hist_if.o_cdf_last   = valid_q && (idx_q == '1);
    assign hist_if.o_frame_done = done_q;
endmodule

// File: tb/tb_hist_cdf_engine.sv
// Directed + randomized bench for hist_cdf_engine: a full-size instance and a
// 4-bit-count instance (IMAGE_SIZE=15), both checked against a per-frame count model.
module tb_hist_cdf_engine;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cnt_m [256];
    int   px_q  [$];

    always #5 clk = ~clk;

    hist_cdf_if #(.PIX_W(8), .CNT_W(19)) bus ();
    hist_cdf_if #(.PIX_W(8), .CNT_W(4))  bus_s ();

    hist_cdf_engine #(.PIX_W(8), .IMAGE_SIZE(640*480)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .hist_if(bus));
    hist_cdf_engine #(.PIX_W(8), .IMAGE_SIZE(15)) dut_s (
        .i_clk(clk), .i_reset_n(rst_n), .hist_if(bus_s));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit sm, input int pix, input bit vld, input bit fe);
        if (sm) begin
            bus_s.i_pixel = 8'(pix); bus_s.i_pixel_valid = vld; bus_s.i_frame_end = fe;
        end else begin
            bus.i_pixel = 8'(pix); bus.i_pixel_valid = vld; bus.i_frame_end = fe;
        end
    endtask

    task automatic set_ready(input bit sm, input bit r);
        if (sm) bus_s.i_cdf_ready = r; else bus.i_cdf_ready = r;
    endtask

    function automatic logic [63:0] beat(input bit sm);
        if (sm) return 64'({bus_s.o_cdf_valid, bus_s.o_cdf_last, bus_s.o_cdf_bin, 32'(bus_s.o_cdf_data)});
        return 64'({bus.o_cdf_valid, bus.o_cdf_last, bus.o_cdf_bin, 32'(bus.o_cdf_data)});
    endfunction

    function automatic bit get_valid(input bit sm);
        return sm ? bus_s.o_cdf_valid : bus.o_cdf_valid;
    endfunction

    function automatic bit get_done(input bit sm);
        return sm ? bus_s.o_frame_done : bus.o_frame_done;
    endfunction

    function automatic bit get_busy(input bit sm);
        return sm ? bus_s.o_busy : bus.o_busy;
    endfunction

    // Pixels from px_q, frame_end with the last pixel or on its own afterwards.
    task automatic send(input bit sm, input bit fe_with_last, input bit gaps);
        for (int i = 0; i < px_q.size(); i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                @(negedge clk); drive(sm, 0, 1'b0, 1'b0);
            end
            @(negedge clk);
            drive(sm, px_q[i], 1'b1, fe_with_last && (i == px_q.size() - 1));
            cnt_m[px_q[i]]++;
        end
        @(negedge clk); drive(sm, 0, 1'b0, 1'b0);
        if (!fe_with_last) begin
            drive(sm, 0, 1'b0, 1'b1);
            @(negedge clk); drive(sm, 0, 1'b0, 1'b0);
        end
        px_q.delete();
    endtask

    task automatic wait_valid(input bit sm);
        int n = 0;
        while (!get_valid(sm) && n < 100) begin @(negedge clk); n++; end
        check("wait_valid", 64'(get_valid(sm)), 64'd1);
    endtask

    task automatic wait_clear(input bit sm, input string tag);
        int n = 0;
        while (get_busy(sm) && n < 400) begin @(negedge clk); n++; end
        check(tag, 64'(n), 64'd256);
    endtask

    // Accept all 256 beats; compare each with the prefix sum of saturated counts.
    task automatic collect(input bit sm, input bit rnd_ready);
        int maxv = sm ? 15 : (1 << 19) - 1;
        int expv [256];
        int run = 0;
        int k = 0, cyc = 0, dones = 0;
        bit held = 1'b0, r;
        logic [63:0] hv, cur;
        for (int b = 0; b < 256; b++) begin
            int c = (cnt_m[b] > maxv) ? maxv : cnt_m[b];
            run = (run + c > maxv) ? maxv : run + c;
            expv[b] = run;
        end
        while (k < 256 && cyc < 5000) begin
            @(negedge clk); cyc++;
            cur = beat(sm);
            if (get_done(sm)) dones++;
            if (held) begin check("hold_stable", cur, hv); held = 1'b0; end
            if (get_valid(sm)) begin
                r = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
                set_ready(sm, r);
                if (r) begin
                    check($sformatf("beat%0d", k), cur,
                          64'({1'b1, k == 255, 8'(k), 32'(expv[k])}));
                    k++;
                end else begin
                    held = 1'b1; hv = cur;
                end
            end
        end
        check("beat_count", 64'(k), 64'd256);
        check("no_early_done", 64'(dones), 64'd0);
        @(negedge clk);
        check("frame_done", 64'({get_done(sm), get_valid(sm)}), 64'b10);
        @(negedge clk);
        check("frame_done_end", 64'(get_done(sm)), 64'd0);
        set_ready(sm, 1'b1);
        foreach (cnt_m[i]) cnt_m[i] = 0;
    endtask

    initial begin
        foreach (cnt_m[i]) cnt_m[i] = 0;
        drive(0, 0, 1'b0, 1'b0); drive(1, 0, 1'b0, 1'b0);
        set_ready(0, 1'b1); set_ready(1, 1'b1);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outputs", 64'({bus.o_cdf_valid, bus.o_drop_err, bus.o_frame_done,
                                  bus.o_cdf_last, bus.o_cdf_bin, 32'(bus.o_cdf_data)}), 64'd0);
        check("rst_busy", 64'({bus.o_busy, bus_s.o_busy}), 64'b11);
`ifdef HIST_CDF_MIN_EN
        check("rst_cdf_min", 64'(bus.o_cdf_min), 64'd0);
`endif
        rst_n = 1'b1;
        wait_clear(0, "clear_cycles");
        check("small_ready", 64'(bus_s.o_busy), 64'd0);

        // 1: small known frame
        px_q = '{3, 3, 3, 7};
        send(0, 1'b0, 1'b0);
        collect(0, 1'b0);

        // 2: 1000 same-bin pixels at full rate, twice
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 1000; i++) px_q.push_back(5);
            send(0, 1'b0, 1'b0);
            collect(0, 1'b0);
        end

        // 3: random frames with gaps and random ready
        for (int f = 0; f < 2; f++) begin
            int n = $urandom_range(50, 400);
            for (int i = 0; i < n; i++) px_q.push_back($urandom_range(0, 255));
            send(0, 1'b0, 1'b1);
            collect(0, 1'b1);
        end

        // 4: pixel with frame_end, then a pixel during SCAN is dropped
        set_ready(0, 1'b0);
        px_q = '{10};
        send(0, 1'b1, 1'b0);
        wait_valid(0);
        drive(0, 20, 1'b1, 1'b0);
        @(negedge clk); drive(0, 0, 1'b0, 1'b0);
        check("drop_err", 64'(bus.o_drop_err), 64'd1);
        collect(0, 1'b1);
        check("drop_err_clear", 64'(bus.o_drop_err), 64'd0);
        for (int i = 0; i < 60; i++) px_q.push_back($urandom_range(0, 255));
        send(0, 1'b0, 1'b1);
        collect(0, 1'b0);

        // Empty frame
        send(0, 1'b0, 1'b0);
        collect(0, 1'b0);

        // 5: saturation on the 4-bit instance
        for (int i = 0; i < 20; i++) px_q.push_back(0);
        send(1, 1'b0, 1'b0);
        collect(1, 1'b0);
        for (int i = 0; i < 40; i++) px_q.push_back($urandom_range(0, 2));
        send(1, 1'b0, 1'b1);
        collect(1, 1'b1);
`ifdef HIST_CDF_MIN_EN
        px_q = '{9, 9, 200};
        send(0, 1'b0, 1'b0);
        collect(0, 1'b0);
        check("cdf_min", 64'(bus.o_cdf_min), 64'd2);
`endif

        // 6: async reset at beat 100 of SCAN
        for (int i = 0; i < 200; i++) px_q.push_back($urandom_range(0, 255));
        send(0, 1'b0, 1'b1);
        set_ready(0, 1'b1);
        wait_valid(0);
        repeat (100) @(negedge clk);
        check("abort_bin", 64'({bus.o_cdf_valid, bus.o_cdf_bin}), 64'({1'b1, 8'd100}));
        rst_n = 1'b0;
        #1;
        check("abort_valid", 64'({bus.o_cdf_valid, bus.o_busy}), 64'b01);
        foreach (cnt_m[i]) cnt_m[i] = 0;
        @(negedge clk); rst_n = 1'b1;
        wait_clear(0, "reclear_cycles");
        px_q = '{1};
        send(0, 1'b0, 1'b0);
        collect(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
